interruption_logic_mbp: RTL and testbench

- Parametrised successor of the task-clock interruption logic.
- Gates the task clock through a clock-enable output for an external BUFGCE.
- Counts delivered task-clock cycles and halts on any of several programmable breakpoints, on a single-step budget, or on an external interrupt request.
- Runs the stop_req/stop_ack/decouple/pr_done handshake toward NUM_TI_WRAPPERS wrappers internally, so no separate ti_controller is needed.

---
 rtl/interruption_logic_mbp.sv | 162 ++++++++++++++++
 tb/tb_interruption_logic_mbp.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interruption_logic_mbp.sv
// ==========================================================================
// interruption_logic_mbp - task-clock gating with breakpoints, stepping and
// the stop/decouple/restore handshake toward the task-interruption wrappers.
// Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module interruption_logic_mbp #(
  parameter int NUM_TI_WRAPPERS = 1,
  parameter int NUM_BP          = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                          sys_clk,
  input  logic                          sys_reset_n,
  input  logic                          clk_en,
  input  logic [NUM_BP*CNT_WIDTH-1:0]   bp_value,
  input  logic [NUM_BP-1:0]             bp_enable,
  input  logic                          step_load,
  input  logic [CNT_WIDTH-1:0]          step_count,
  input  logic                          ti_req,
  input  logic                          resume,
  input  logic                          counter_clear,
  input  logic                          pr_done,
  input  logic [NUM_TI_WRAPPERS-1:0]    stop_ack,
  output logic                          task_ce,
  output logic [CNT_WIDTH-1:0]          cycle_count,
  output logic [NUM_TI_WRAPPERS-1:0]    stop_req,
  output logic                          decouple,
  output logic [2:0]                    halt_cause,
  output logic [NUM_BP-1:0]             bp_hit,
  output logic [2:0]                    state
);

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_STOPPING  = 3'd1,
    ST_DECOUPLED = 3'd2,
    ST_RESTORE   = 3'd3,
    ST_HALTED    = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                        state_r;
  logic                          clk_en_r;
  logic                          ti_req_r;
  logic                          skip;
  logic                          step_armed;
  logic [CNT_WIDTH-1:0]          step_budget;
  logic [NUM_BP*CNT_WIDTH-1:0]   bp_value_r;
  logic [NUM_BP-1:0]             bp_enable_r;

  logic [NUM_BP-1:0]             bp_match;
  logic                          hit;
  logic                          step_done;
  logic                          ti_edge;
  logic                          halt_event;
  logic                          run_or_halted;

  // Breakpoint settings are registered so task_ce never sees an input directly.
  generate
    for (genvar i = 0; i < NUM_BP; i++) begin : g_bp_cmp
      assign bp_match[i] = bp_enable_r[i] && !skip &&
                           (bp_value_r[i*CNT_WIDTH +: CNT_WIDTH] == cycle_count) &&
                           (bp_value_r[i*CNT_WIDTH +: CNT_WIDTH] != CNT_MAX);
    end
  endgenerate

  assign hit           = |bp_match;
  assign step_done     = step_armed && (step_budget == '0);
  assign ti_edge       = ti_req && !ti_req_r;
  assign halt_event    = hit || step_done || ti_edge;
  assign run_or_halted = (state_r == ST_RUN) || (state_r == ST_HALTED);
  assign task_ce       = clk_en_r && (state_r == ST_RUN) && !hit && !step_done;
  assign state         = state_r;

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_r     <= ST_RUN;
      clk_en_r    <= 1'b0;
      ti_req_r    <= 1'b0;
      skip        <= 1'b0;
      step_armed  <= 1'b0;
      step_budget <= '0;
      bp_value_r  <= '0;
      bp_enable_r <= '0;
      cycle_count <= '0;
      stop_req    <= '0;
      decouple    <= 1'b0;
      halt_cause  <= '0;
      bp_hit      <= '0;
    end else begin
      clk_en_r    <= clk_en;
      ti_req_r    <= ti_req;
      bp_value_r  <= bp_value;
      bp_enable_r <= bp_enable;

      if (counter_clear && run_or_halted) begin
        cycle_count <= '0;
        skip        <= 1'b0;
      end else if (task_ce) begin
        if (cycle_count != CNT_MAX)
          cycle_count <= cycle_count + CNT_ONE;
        skip <= 1'b0;
      end

      // An armed budget is nonzero whenever task_ce is high, so no underflow.
      if (task_ce && step_armed)
        step_budget <= step_budget - CNT_ONE;

      case (state_r)
        ST_RUN: begin
          if (halt_event) begin
            state_r    <= ST_STOPPING;
            stop_req   <= '1;
            halt_cause <= halt_cause | {step_done, ti_edge, hit};
            bp_hit     <= bp_hit | bp_match;
            if (step_done)
              step_armed <= 1'b0;
          end
        end
        ST_STOPPING: begin
          if (&stop_ack) begin
            state_r  <= ST_DECOUPLED;
            decouple <= 1'b1;
          end
        end
        ST_DECOUPLED: begin
          if (pr_done) begin
            state_r  <= ST_RESTORE;
            decouple <= 1'b0;
            stop_req <= '0;
          end
        end
        ST_RESTORE: begin
          if (!(|stop_ack))
            state_r <= ST_HALTED;
        end
        ST_HALTED: begin
          if (resume) begin
            state_r    <= ST_RUN;
            halt_cause <= '0;
            bp_hit     <= '0;
            skip       <= 1'b1;
          end
        end
        default: state_r <= ST_RUN;
      endcase

      // A fresh load overrides the disarm of a budget that just expired.
      if (step_load && run_or_halted) begin
        step_budget <= step_count;
        step_armed  <= |step_count;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_interruption_logic_mbp.sv
// ==========================================================================
// tb_interruption_logic_mbp - directed scoreboard bench for interruption_logic_mbp.
// Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_interruption_logic_mbp;

  localparam int NW = 3;
  localparam int NB = 4;
  localparam int CW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clk_en = 1'b0;
  logic [NB*CW-1:0]  bp_value = '1;
  logic [NB-1:0]     bp_enable = '0;
  logic              step_load = 1'b0;
  logic [CW-1:0]     step_count = '0;
  logic              ti_req = 1'b0;
  logic              resume = 1'b0;
  logic              counter_clear = 1'b0;
  logic              pr_done = 1'b0;
  logic [NW-1:0]     stop_ack;
  logic [NW-1:0]     ack_man = '0;
  logic              auto_ack = 1'b1;
  logic [1:0]        ack_sh;

  logic              task_ce;
  logic [CW-1:0]     cycle_count;
  logic [NW-1:0]     stop_req;
  logic              decouple;
  logic [2:0]        halt_cause;
  logic [NB-1:0]     bp_hit;
  logic [2:0]        state;

  always #5 clk = ~clk;

  interruption_logic_mbp #(
    .NUM_TI_WRAPPERS(NW),
    .NUM_BP(NB),
    .CNT_WIDTH(CW)
  ) dut (
    .sys_clk(clk),
    .sys_reset_n(rst_n),
    .clk_en(clk_en),
    .bp_value(bp_value),
    .bp_enable(bp_enable),
    .step_load(step_load),
    .step_count(step_count),
    .ti_req(ti_req),
    .resume(resume),
    .counter_clear(counter_clear),
    .pr_done(pr_done),
    .stop_ack(stop_ack),
    .task_ce(task_ce),
    .cycle_count(cycle_count),
    .stop_req(stop_req),
    .decouple(decouple),
    .halt_cause(halt_cause),
    .bp_hit(bp_hit),
    .state(state)
  );

  // Wrapper model: all wrappers acknowledge two cycles after stop_req changes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sh <= '0;
    else        ack_sh <= {ack_sh[0], stop_req[0]};
  end
  assign stop_ack = auto_ack ? {NW{ack_sh[1]}} : ack_man;

  typedef struct {
    logic [CW-1:0] count;
    logic [2:0]    cause;
    logic [NB-1:0] hits;
    int            ce;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ce_cnt = 0;
  logic [2:0] prev_state = 3'd0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each entry into HALTED is one observed response.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_state = 3'd0;
      ce_cnt = 0;
    end else begin
      if (state == 3'd4 && prev_state != 3'd4) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_halt", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("halt_count", int'(cycle_count), int'(mon_e.count));
          chk("halt_cause", int'(halt_cause), int'(mon_e.cause));
          chk("halt_bp_hit", int'(bp_hit), int'(mon_e.hits));
          chk("ce_cycles", ce_cnt, mon_e.ce);
        end
        ce_cnt = 0;
      end else if (task_ce) begin
        ce_cnt++;
      end
      prev_state = state;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    for (int i = 0; i < budget && state != s; i++) tick(1);
    chk(name, int'(state), int'(s));
  endtask

  task automatic set_bp(input int idx, input logic [CW-1:0] val);
    bp_value[idx*CW +: CW] = val;
  endtask

  task automatic pulse_resume();
    resume = 1'b1;
    tick(1);
    resume = 1'b0;
  endtask

  task automatic handshake(input string name);
    wait_state(3'd2, 300, {name, "_decoupled"});
    tick(5);
    pr_done = 1'b1;
    tick(1);
    pr_done = 1'b0;
    wait_state(3'd4, 20, {name, "_halted"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_task_ce", int'(task_ce), 0);
    chk("rst_count", int'(cycle_count), 0);
    chk("rst_stop_req", int'(stop_req), 0);
    chk("rst_decouple", int'(decouple), 0);
    chk("rst_halt_cause", int'(halt_cause), 0);
    chk("rst_bp_hit", int'(bp_hit), 0);
    chk("rst_state", int'(state), 0);
    rst_n = 1'b1;
    tick(1);

    // Breakpoint at 10: exactly ten task-clock cycles delivered.
    set_bp(0, 8'd10);
    bp_enable = 4'b0001;
    clk_en = 1'b1;
    sb_q.push_back('{8'd10, 3'b001, 4'b0001, 10});
    wait_state(3'd2, 40, "bp0_decoupled");
    chk("bp0_dec_count", int'(cycle_count), 10);
    chk("bp0_dec_stop_req", int'(stop_req), 7);
    chk("bp0_dec_decouple", int'(decouple), 1);
    tick(5);
    pr_done = 1'b1;
    tick(1);
    pr_done = 1'b0;
    wait_state(3'd4, 20, "bp0_halted");

    // Resume from the breakpoint, next stop at 15.
    set_bp(1, 8'd15);
    bp_enable = 4'b0011;
    sb_q.push_back('{8'd15, 3'b001, 4'b0010, 5});
    tick(1);
    pulse_resume();
    chk("res_state", int'(state), 0);
    chk("res_cause_clr", int'(halt_cause), 0);
    chk("res_bp_hit_clr", int'(bp_hit), 0);
    tick(1);
    chk("res_count_11", int'(cycle_count), 11);
    chk("res_no_rehalt", int'(state), 0);
    handshake("bp1");

    // Single step budget of three.
    bp_enable = 4'b0000;
    step_count = 8'd3;
    step_load = 1'b1;
    tick(1);
    step_load = 1'b0;
    sb_q.push_back('{8'd18, 3'b100, 4'b0000, 3});
    pulse_resume();
    handshake("step");

    // ti_req edge coinciding with the breakpoint at 7.
    counter_clear = 1'b1;
    tick(1);
    counter_clear = 1'b0;
    chk("clear_count", int'(cycle_count), 0);
    set_bp(2, 8'd7);
    bp_enable = 4'b0100;
    sb_q.push_back('{8'd7, 3'b011, 4'b0100, 7});
    tick(1);
    pulse_resume();
    tick(7);
    chk("sim_count", int'(cycle_count), 7);
    chk("sim_ce_low_at_hit", int'(task_ce), 0);
    ti_req = 1'b1;
    handshake("sim");
    ti_req = 1'b0;
    tick(1);

    // Three-wrapper handshake driven by hand.
    auto_ack = 1'b0;
    ack_man = 3'b000;
    bp_enable = 4'b0000;
    sb_q.push_back('{8'd8, 3'b010, 4'b0000, 1});
    pulse_resume();
    ti_req = 1'b1;
    tick(1);
    ti_req = 1'b0;
    chk("mw_stopping", int'(state), 1);
    chk("mw_stop_req", int'(stop_req), 7);
    ack_man = 3'b011;
    tick(3);
    chk("mw_partial_ack", int'(state), 1);
    pr_done = 1'b1;
    tick(1);
    pr_done = 1'b0;
    chk("mw_pr_done_ignored", int'(state), 1);
    ack_man = 3'b111;
    tick(1);
    chk("mw_decoupled", int'(state), 2);
    chk("mw_decouple", int'(decouple), 1);
    pulse_resume();
    chk("mw_resume_ignored", int'(state), 2);
    pr_done = 1'b1;
    tick(1);
    pr_done = 1'b0;
    chk("mw_restore", int'(state), 3);
    chk("mw_restore_stop_req", int'(stop_req), 0);
    chk("mw_restore_decouple", int'(decouple), 0);
    ack_man = 3'b001;
    tick(2);
    chk("mw_restore_hold", int'(state), 3);
    ack_man = 3'b000;
    tick(1);
    chk("mw_halted", int'(state), 4);
    tick(1);

    // All-ones breakpoint never fires; counter saturates.
    auto_ack = 1'b1;
    counter_clear = 1'b1;
    tick(1);
    counter_clear = 1'b0;
    set_bp(3, 8'hFF);
    bp_enable = 4'b1000;
    tick(1);
    pulse_resume();
    tick(270);
    chk("sat_count", int'(cycle_count), 255);
    chk("sat_state", int'(state), 0);
    chk("sat_task_ce", int'(task_ce), 1);

    // clk_en takes one cycle to reach task_ce.
    clk_en = 1'b0;
    chk("ce_latency_hold", int'(task_ce), 1);
    tick(1);
    chk("ce_off", int'(task_ce), 0);

    // Asynchronous reset while DECOUPLED.
    clk_en = 1'b1;
    ti_req = 1'b1;
    tick(1);
    ti_req = 1'b0;
    wait_state(3'd2, 20, "arst_decoupled");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_decouple", int'(decouple), 0);
    chk("arst_stop_req", int'(stop_req), 0);
    chk("arst_state", int'(state), 0);
    chk("arst_count", int'(cycle_count), 0);

    chk("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
